// File: rtl/uart_rx_frame_parser_if.sv
// rtl/uart_rx_frame_parser_if.sv - held-frame handshake and payload readout bundle
interface uart_rx_frame_parser_if #(
  parameter int MAX_PAYLOAD = 16
);

  localparam int ADDR_W = $clog2(MAX_PAYLOAD);
  localparam int LEN_W  = $clog2(MAX_PAYLOAD + 1);

  logic              frame_valid;
  logic              frame_ready;
  logic [LEN_W-1:0]  frame_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  // Parser side: offers the frame and serves reads.
  modport master (
    output frame_valid,
    output frame_len,
    output rd_data,
    input  frame_ready,
    input  rd_addr
  );

  // Command decoder side: accepts the frame and indexes the payload.
  modport slave (
    input  frame_valid,
    input  frame_len,
    input  rd_data,
    output frame_ready,
    output rd_addr
  );

endinterface

// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - SYNC/LEN/payload/CHK frame parser behind a UART receiver; optional stats via UART_FRAME_STATS_EN
module uart_rx_frame_parser #(
  parameter int         MAX_PAYLOAD  = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 8680
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst,
  input  logic                          i_RX_Done,
  input  logic [7:0]                    i_RX_Byte,
  uart_rx_frame_parser_if.master        frame_if,
  output logic                          o_Len_Err,
  output logic                          o_Chk_Err,
  output logic                          o_Timeout_Err,
  output logic                          o_Overrun_Err
`ifdef UART_FRAME_STATS_EN
  ,
  output logic [15:0]                   o_Frame_Count,
  output logic [15:0]                   o_Err_Count
`endif
);

  localparam int ADDR_W = $clog2(MAX_PAYLOAD);
  localparam int LEN_W  = $clog2(MAX_PAYLOAD + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DATA,
    GET_CHK,
    HOLD
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] idx;
  logic [TO_W-1:0]   to_cnt;
  logic              frame_valid;
  logic [LEN_W-1:0]  frame_len;

  // Sized to the full address range so any rd_addr indexes a real entry.
  logic [7:0] payload_mem [0:(2**ADDR_W)-1];

  logic       in_frame;
  logic       to_hit;
  logic       len_bad;
  logic       last_data;
  logic [7:0] chk_sum;

  // A byte arriving on the limit cycle suppresses the timeout.
  assign in_frame  = (state == GET_LEN) || (state == GET_DATA) || (state == GET_CHK);
  assign to_hit    = in_frame && !i_RX_Done && (to_cnt == TO_LIMIT);
  assign len_bad   = (i_RX_Byte == 8'h00) || (i_RX_Byte > 8'(MAX_PAYLOAD));
  assign last_data = (LEN_W'(idx) == (len - LEN_W'(1)));
  assign chk_sum   = sum + i_RX_Byte;

  assign frame_if.frame_valid = frame_valid;
  assign frame_if.frame_len   = frame_len;
  assign frame_if.rd_data     = payload_mem[frame_if.rd_addr];

  // Frame state machine, checksum accumulator, inter-byte timer and error pulses.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state         <= IDLE;
      len           <= '0;
      sum           <= '0;
      idx           <= '0;
      to_cnt        <= '0;
      frame_valid   <= 1'b0;
      frame_len     <= '0;
      o_Len_Err     <= 1'b0;
      o_Chk_Err     <= 1'b0;
      o_Timeout_Err <= 1'b0;
      o_Overrun_Err <= 1'b0;
    end else begin
      o_Len_Err     <= 1'b0;
      o_Chk_Err     <= 1'b0;
      o_Timeout_Err <= 1'b0;
      o_Overrun_Err <= 1'b0;

      // Timer only advances while waiting for the next byte of a frame.
      if (in_frame && !i_RX_Done && !to_hit) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (i_RX_Done && (i_RX_Byte == SYNC_BYTE)) begin
            state <= GET_LEN;
          end
        end

        GET_LEN: begin
          if (i_RX_Done) begin
            if (len_bad) begin
              o_Len_Err <= 1'b1;
              state     <= IDLE;
            end else begin
              len   <= i_RX_Byte[LEN_W-1:0];
              sum   <= i_RX_Byte;
              idx   <= '0;
              state <= GET_DATA;
            end
          end else if (to_hit) begin
            o_Timeout_Err <= 1'b1;
            state         <= IDLE;
          end
        end

        GET_DATA: begin
          if (i_RX_Done) begin
            sum <= chk_sum;
            idx <= idx + ADDR_W'(1);
            if (last_data) begin
              state <= GET_CHK;
            end
          end else if (to_hit) begin
            o_Timeout_Err <= 1'b1;
            state         <= IDLE;
          end
        end

        GET_CHK: begin
          if (i_RX_Done) begin
            if (chk_sum == 8'h00) begin
              frame_len   <= len;
              frame_valid <= 1'b1;
              state       <= HOLD;
            end else begin
              o_Chk_Err <= 1'b1;
              state     <= IDLE;
            end
          end else if (to_hit) begin
            o_Timeout_Err <= 1'b1;
            state         <= IDLE;
          end
        end

        HOLD: begin
          if (i_RX_Done) begin
            o_Overrun_Err <= 1'b1;
          end
          if (frame_valid && frame_if.frame_ready) begin
            frame_valid <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Payload storage; written only while collecting data so HOLD keeps it frozen.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst && (state == GET_DATA) && i_RX_Done) begin
      payload_mem[idx] <= i_RX_Byte;
    end
  end

`ifdef UART_FRAME_STATS_EN
  logic xfer;
  logic err_pulse;

  assign xfer      = (state == HOLD) && frame_valid && frame_if.frame_ready;
  assign err_pulse = o_Len_Err || o_Chk_Err || o_Timeout_Err;

  // Wrapping transfer count and saturating framing-error count.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      o_Frame_Count <= '0;
      o_Err_Count   <= '0;
    end else begin
      if (xfer) begin
        o_Frame_Count <= o_Frame_Count + 16'd1;
      end
      if (err_pulse && (o_Err_Count != 16'hFFFF)) begin
        o_Err_Count <= o_Err_Count + 16'd1;
      end
    end
  end
`endif

endmodule
